aes_round_sequencer: RTL and testbench

Iterative control unit that time-shares a single AES round datapath and key-expansion unit across all rounds of one block operation. It accepts a block request over a valid/ready handshake, selects the round count from the key length (128/192/256), drives per-round control strobes and round index, and presents completion over a valid/ready output handshake. It sits between the host-side block interface and the round/key-expansion datapath, replacing the unrolled per-round instance chain.

---
 rtl/aes_round_sequencer_if.sv | 31 +++
 rtl/aes_round_sequencer.sv | 211 +++++++++++++++++++++
 tb/tb_aes_round_sequencer.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/aes_round_sequencer_if.sv
// Host-side block handshake for the AES round sequencer.
// Request fields travel with in_valid; the result handshake is out_valid/out_ready.
interface aes_round_sequencer_if;
  logic       in_valid;
  logic       in_ready;
  logic [1:0] key_len;
  logic       decrypt;
  logic       key_reuse;
  logic       out_valid;
  logic       out_ready;

  modport master (
    output in_valid,
    output key_len,
    output decrypt,
    output key_reuse,
    output out_ready,
    input  in_ready,
    input  out_valid
  );

  modport slave (
    input  in_valid,
    input  key_len,
    input  decrypt,
    input  key_reuse,
    input  out_ready,
    output in_ready,
    output out_valid
  );
endinterface

// File: rtl/aes_round_sequencer.sv
// Iterative AES round/key-expansion sequencer: one shared round datapath,
// Nr chosen from key length, optional decrypt key-schedule cache.
module aes_round_sequencer #(
  parameter int IDX_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  aes_round_sequencer_if.slave host,
  output logic             dp_load,
  output logic             dp_init,
  output logic             dp_round_en,
  output logic             dp_last,
  output logic [IDX_W-1:0] round_idx,
  output logic             kexp_en,
  output logic [IDX_W-1:0] kexp_idx,
  output logic             busy,
  output logic             err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_KEYGEN,
    S_INIT,
    S_ROUND,
    S_FINAL,
    S_OUT
  } state_e;

  state_e state_q, state_d;

  logic [IDX_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0] nr_q, nr_d;
  logic             dec_q, dec_d;
  logic             cv_q, cv_d;
  logic [IDX_W-1:0] cnr_q, cnr_d;
  logic [IDX_W-1:0] nr_sel;
  logic             hit;

  logic             in_ready_q, in_ready_d;
  logic             busy_q, busy_d;
  logic             err_q, err_d;
  logic             init_q, init_d;
  logic             ren_q, ren_d;
  logic             last_q, last_d;
  logic [IDX_W-1:0] ridx_q, ridx_d;
  logic             ken_q, ken_d;
  logic [IDX_W-1:0] kidx_q, kidx_d;
  logic             ov_q, ov_d;

  always_comb begin
    nr_sel = IDX_W'(10);
    unique case (host.key_len)
      2'd1:    nr_sel = IDX_W'(12);
      2'd2:    nr_sel = IDX_W'(14);
      default: nr_sel = IDX_W'(10);
    endcase
  end

  // Cached schedule is only usable if it was built for the same Nr
  assign hit = host.key_reuse & cv_q & (cnr_q == nr_sel);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    nr_d    = nr_q;
    dec_d   = dec_q;
    cv_d    = cv_q;
    cnr_d   = cnr_q;
    err_d   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (host.in_valid) begin
          if (host.key_len == 2'd3) begin
            err_d = 1'b1;
          end else begin
            nr_d  = nr_sel;
            dec_d = host.decrypt;
            if (!host.decrypt) begin
              cv_d    = 1'b0;
              state_d = S_INIT;
            end else if (hit) begin
              state_d = S_INIT;
            end else begin
              cnt_d   = IDX_W'(1);
              state_d = S_KEYGEN;
            end
          end
        end
      end
      S_KEYGEN: begin
        if (cnt_q == nr_q) begin
          cv_d    = 1'b1;
          cnr_d   = nr_q;
          state_d = S_INIT;
        end else begin
          cnt_d = cnt_q + IDX_W'(1);
        end
      end
      S_INIT: begin
        cnt_d   = IDX_W'(1);
        state_d = S_ROUND;
      end
      S_ROUND: begin
        if (cnt_q == nr_q - IDX_W'(1)) begin
          state_d = S_FINAL;
        end else begin
          cnt_d = cnt_q + IDX_W'(1);
        end
      end
      S_FINAL: state_d = S_OUT;
      S_OUT: begin
        if (host.out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they come straight off flops
  always_comb begin
    in_ready_d = (state_d == S_IDLE);
    busy_d     = (state_d != S_IDLE);
    init_d     = 1'b0;
    ren_d      = 1'b0;
    last_d     = 1'b0;
    ridx_d     = '0;
    ken_d      = 1'b0;
    kidx_d     = '0;
    ov_d       = 1'b0;
    unique case (state_d)
      S_KEYGEN: begin
        ken_d  = 1'b1;
        kidx_d = cnt_d;
      end
      S_INIT: begin
        init_d = 1'b1;
        ridx_d = dec_d ? nr_d : '0;
      end
      S_ROUND: begin
        ren_d  = 1'b1;
        ridx_d = dec_d ? nr_d - cnt_d : cnt_d;
      end
      S_FINAL: begin
        ren_d  = 1'b1;
        last_d = 1'b1;
        ridx_d = dec_d ? '0 : nr_d;
      end
      S_OUT: ov_d = 1'b1;
      default: ;
    endcase
    if (!dec_d && (state_d == S_ROUND || state_d == S_FINAL)) begin
      ken_d  = 1'b1;
      kidx_d = ridx_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      nr_q       <= '0;
      dec_q      <= 1'b0;
      cv_q       <= 1'b0;
      cnr_q      <= '0;
      in_ready_q <= 1'b1;
      busy_q     <= 1'b0;
      err_q      <= 1'b0;
      init_q     <= 1'b0;
      ren_q      <= 1'b0;
      last_q     <= 1'b0;
      ridx_q     <= '0;
      ken_q      <= 1'b0;
      kidx_q     <= '0;
      ov_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      nr_q       <= nr_d;
      dec_q      <= dec_d;
      cv_q       <= cv_d;
      cnr_q      <= cnr_d;
      in_ready_q <= in_ready_d;
      busy_q     <= busy_d;
      err_q      <= err_d;
      init_q     <= init_d;
      ren_q      <= ren_d;
      last_q     <= last_d;
      ridx_q     <= ridx_d;
      ken_q      <= ken_d;
      kidx_q     <= kidx_d;
      ov_q       <= ov_d;
    end
  end

  // Load strobe marks the accepting cycle itself so the datapath captures
  // the block on the same edge the request is taken
  assign dp_load = in_ready_q & host.in_valid & (host.key_len != 2'd3);

  assign host.in_ready  = in_ready_q;
  assign host.out_valid = ov_q;
  assign dp_init        = init_q;
  assign dp_round_en    = ren_q;
  assign dp_last        = last_q;
  assign round_idx      = ridx_q;
  assign kexp_en        = ken_q;
  assign kexp_idx       = kidx_q;
  assign busy           = busy_q;
  assign err            = err_q;

endmodule

// File: tb/tb_aes_round_sequencer.sv
// Self-checking bench for aes_round_sequencer: per-cycle expected traces
// built from round-order lists and a key-cache model.
module tb_aes_round_sequencer;

  logic       clk;
  logic       rst_n;
  logic       dp_load;
  logic       dp_init;
  logic       dp_round_en;
  logic       dp_last;
  logic [3:0] round_idx;
  logic       kexp_en;
  logic [3:0] kexp_idx;
  logic       busy;
  logic       err;

  int n_checks = 0;
  int n_errs   = 0;

  bit cache_v  = 1'b0;
  int cache_nr = 0;

  aes_round_sequencer_if ifc();

  aes_round_sequencer #(.IDX_W(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .host        (ifc),
    .dp_load     (dp_load),
    .dp_init     (dp_init),
    .dp_round_en (dp_round_en),
    .dp_last     (dp_last),
    .round_idx   (round_idx),
    .kexp_en     (kexp_en),
    .kexp_idx    (kexp_idx),
    .busy        (busy),
    .err         (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [16:0] mk(
    input bit ir, input bit bsy, input bit er, input bit ld,
    input bit ini, input bit ren, input bit lst, input int ridx,
    input bit ken, input int kidx, input bit ov);
    return {ir, bsy, er, ld, ini, ren, lst, 4'(ridx), ken, 4'(kidx), ov};
  endfunction

  function automatic logic [16:0] obs();
    return {ifc.in_ready, busy, err, dp_load, dp_init, dp_round_en,
            dp_last, round_idx, kexp_en, kexp_idx, ifc.out_valid};
  endfunction

  task automatic check(input string tag, input int cyc,
                       input logic [16:0] o, input logic [16:0] e);
    n_checks++;
    assert (o === e) else begin
      n_errs++;
      $error("FAIL %s cyc %0d: got %h expected %h", tag, cyc, o, e);
    end
  endtask

  task automatic run_op(input logic [1:0] kl, input bit dc, input bit ru,
                        input int stall, input string tag);
    logic [16:0] exp_q[$];
    int ord[$];
    int nr;
    bit kg;
    int out_at;
    bit ken;
    out_at = 100000;
    if (kl == 2'd3) begin
      exp_q.push_back(mk(1,0,0,0,0,0,0,0,0,0,0));
      exp_q.push_back(mk(1,0,1,0,0,0,0,0,0,0,0));
      exp_q.push_back(mk(1,0,0,0,0,0,0,0,0,0,0));
    end else begin
      nr = 10 + 2 * int'(kl);
      kg = dc && !(ru && cache_v && cache_nr == nr);
      exp_q.push_back(mk(1,0,0,1,0,0,0,0,0,0,0));
      if (kg)
        for (int k = 1; k <= nr; k++)
          exp_q.push_back(mk(0,1,0,0,0,0,0,0,1,k,0));
      for (int j = 0; j <= nr; j++)
        ord.push_back(dc ? nr - j : j);
      for (int j = 0; j <= nr; j++) begin
        ken = !dc && j > 0;
        exp_q.push_back(mk(0,1,0,0, j == 0, j > 0, j == nr, ord[j],
                           ken, ken ? ord[j] : 0, 0));
      end
      out_at = exp_q.size();
      for (int s = 0; s <= stall; s++)
        exp_q.push_back(mk(0,1,0,0,0,0,0,0,0,0,1));
      exp_q.push_back(mk(1,0,0,0,0,0,0,0,0,0,0));
      if (kg) begin
        cache_v  = 1'b1;
        cache_nr = nr;
      end
      if (!dc) cache_v = 1'b0;
    end
    @(posedge clk); #1;
    ifc.in_valid  = 1'b1;
    ifc.key_len   = kl;
    ifc.decrypt   = dc;
    ifc.key_reuse = ru;
    ifc.out_ready = 1'($urandom);
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i > 0) begin
        @(posedge clk); #1;
        ifc.in_valid  = 1'b0;
        ifc.key_len   = 2'($urandom);
        ifc.decrypt   = 1'($urandom);
        ifc.key_reuse = 1'($urandom);
        if (i < out_at) ifc.out_ready = 1'($urandom);
        else            ifc.out_ready = (i >= out_at + stall);
      end
      @(negedge clk);
      check(tag, i, obs(), exp_q[i]);
    end
    ifc.out_ready = 1'b0;
  endtask

  initial begin
    rst_n         = 1'b0;
    ifc.in_valid  = 1'b0;
    ifc.key_len   = 2'd0;
    ifc.decrypt   = 1'b0;
    ifc.key_reuse = 1'b0;
    ifc.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_state", 0, obs(), mk(1,0,0,0,0,0,0,0,0,0,0));
    rst_n = 1'b1;

    run_op(2'd0, 1'b0, 1'b0, 0, "enc128");
    run_op(2'd2, 1'b1, 1'b0, 0, "dec256_kg");
    run_op(2'd1, 1'b1, 1'b0, 0, "dec192_kg");
    run_op(2'd1, 1'b1, 1'b1, 0, "dec192_hit");
    run_op(2'd0, 1'b1, 1'b1, 0, "dec128_miss");
    run_op(2'd3, 1'b1, 1'b0, 0, "illegal");
    run_op(2'd1, 1'b0, 1'b0, 5, "stall5");
    run_op(2'd0, 1'b1, 1'b1, 0, "dec_after_enc");
    run_op(2'd2, 1'b0, 1'b0, 2, "enc256");

    // Reset during KEYGEN cycle 5
    @(posedge clk); #1;
    ifc.in_valid  = 1'b1;
    ifc.key_len   = 2'd1;
    ifc.decrypt   = 1'b1;
    ifc.key_reuse = 1'b0;
    @(posedge clk); #1;
    ifc.in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("kg_cyc5", 5, obs(), mk(0,1,0,0,0,0,0,0,1,5,0));
    #1 rst_n = 1'b0;
    #1;
    check("async_rst", 0, obs(), mk(1,0,0,0,0,0,0,0,0,0,0));
    @(posedge clk); #1;
    check("rst_hold", 0, obs(), mk(1,0,0,0,0,0,0,0,0,0,0));
    rst_n   = 1'b1;
    cache_v = 1'b0;
    run_op(2'd1, 1'b1, 1'b1, 0, "post_rst_kg");

    for (int t = 0; t < 25; t++)
      run_op(2'($urandom_range(0, 3)), 1'($urandom), 1'($urandom),
             $urandom_range(0, 3), "random");

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
